// File: rtl/proc_defs.sv
// rtl/proc_defs.sv - shared state encodings and UART byte width
//
// Purpose : definitions shared by the memory sequencer and its helpers.
// Ports   : none (package).

package proc_defs;

   // UART payload width
   localparam int BYTE_W = 8;

   // Sequencer states; the current state also selects the memory port owner
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_WAIT = 3'd1,
      TX_READ = 3'd2,
      TX_LOAD = 3'd3,
      TX_SEND = 3'd4,
      TX_WAIT = 3'd5,
      RUN     = 3'd6
   } state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered rising-edge pulse generator
//
// Purpose : turns a level request into a single-cycle pulse, one cycle after
//           the rising edge is seen. A held level never retriggers.
// Ports   : clk     - system clock
//           reset   - synchronous, active-high
//           level_i - level request input
//           rise_o  - registered 1-cycle pulse on a 0->1 transition

module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic rise_o
);

   logic prev_q;
   logic rise_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= level_i;
         rise_q <= level_i & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - shared data memory sequencer between UART and core
//
// Purpose : loads an image from uart_rx into memory, runs the core, and
//           dumps the image through uart_tx. Exactly one owner drives the
//           memory port at any time, chosen by the FSM state.
// Ports   : clk, reset                - clock, synchronous active-high reset
//           receive, send, enablle    - level requests (rising edge sampled)
//           rx_data, rx_valid         - byte stream from uart_rx
//           tx_busy, tx_data, tx_start- handshake to uart_tx
//           proc_addr/wdata/we/done   - core memory port and completion
//           proc_en                   - core run enable
//           mem_addr/wdata/we, mem_rdata - shared memory port (1-cycle read)
//           rx_LED, tx_LED, enable_check - high in RX, TX, RUN respectively

module uart_mem_ctrl
   import proc_defs::*;
#(
   parameter int ADDR_W    = 16,
   parameter int IMG_BYTES = 65536
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              receive,
   input  logic              send,
   input  logic              enablle,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              tx_busy,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_start,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [BYTE_W-1:0] proc_wdata,
   input  logic              proc_we,
   input  logic              proc_done,
   output logic              proc_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BYTE_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic              rx_LED,
   output logic              tx_LED,
   output logic              enable_check
);

   // One extra bit so a full 2**ADDR_W transfer reaches its end count without wrapping
   localparam int             CNT_W    = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_BYTES);

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [BYTE_W-1:0]   tx_data_q;
   logic                tx_start_q;
   logic                busy_seen_q;
   logic                proc_en_q;
   logic                rx_led_q;
   logic                tx_led_q;
   logic                en_chk_q;

   logic                recv_rise;
   logic                send_rise;
   logic                en_rise;

   rise_detect u_rise_recv (.clk(clk), .reset(reset), .level_i(receive), .rise_o(recv_rise));
   rise_detect u_rise_send (.clk(clk), .reset(reset), .level_i(send),    .rise_o(send_rise));
   rise_detect u_rise_en   (.clk(clk), .reset(reset), .level_i(enablle), .rise_o(en_rise));

   assign cnt_d = cnt_q + 1'b1;

   // Memory port mux. UART writes must land in the same cycle as rx_valid,
   // so this path is combinational from the registered state.
   always_comb begin
      mem_addr  = proc_addr;
      mem_wdata = proc_wdata;
      mem_we    = 1'b0;
      case (state_q)
         RX_WAIT: begin
            mem_addr  = cnt_q[ADDR_W-1:0];
            mem_wdata = rx_data;
            mem_we    = rx_valid;
         end
         TX_READ, TX_LOAD, TX_SEND, TX_WAIT: begin
            mem_addr  = cnt_q[ADDR_W-1:0];
            mem_wdata = '0;
         end
         RUN: begin
            mem_we = proc_we;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tx_data_q   <= '0;
         tx_start_q  <= 1'b0;
         busy_seen_q <= 1'b0;
         proc_en_q   <= 1'b0;
         rx_led_q    <= 1'b0;
         tx_led_q    <= 1'b0;
         en_chk_q    <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               // Priority receive > send > enablle when edges coincide
               if (recv_rise) begin
                  state_q  <= RX_WAIT;
                  rx_led_q <= 1'b1;
               end else if (send_rise) begin
                  state_q  <= TX_READ;
                  tx_led_q <= 1'b1;
               end else if (en_rise) begin
                  state_q   <= RUN;
                  proc_en_q <= 1'b1;
                  en_chk_q  <= 1'b1;
               end
            end
            RX_WAIT: begin
               if (rx_valid) begin
                  if (cnt_d == CNT_LAST) begin
                     cnt_q    <= '0;
                     state_q  <= IDLE;
                     rx_led_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            TX_READ: begin
               state_q <= TX_LOAD;
            end
            TX_LOAD: begin
               tx_data_q <= mem_rdata;
               state_q   <= TX_SEND;
            end
            TX_SEND: begin
               if (!tx_busy) begin
                  tx_start_q  <= 1'b1;
                  busy_seen_q <= 1'b0;
                  state_q     <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               // A byte is done only after busy has been seen high and then low
               if (tx_busy) begin
                  busy_seen_q <= 1'b1;
               end else if (busy_seen_q) begin
                  busy_seen_q <= 1'b0;
                  if (cnt_d == CNT_LAST) begin
                     cnt_q    <= '0;
                     state_q  <= IDLE;
                     tx_led_q <= 1'b0;
                  end else begin
                     cnt_q   <= cnt_d;
                     state_q <= TX_READ;
                  end
               end
            end
            RUN: begin
               if (proc_done) begin
                  proc_en_q <= 1'b0;
                  en_chk_q  <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_start     = tx_start_q;
   assign proc_en      = proc_en_q;
   assign rx_LED       = rx_led_q;
   assign tx_LED       = tx_led_q;
   assign enable_check = en_chk_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - directed self-checking bench for uart_mem_ctrl

module tb_uart_mem_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       receive, send, enablle;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [3:0] proc_addr;
   logic [7:0] proc_wdata;
   logic       proc_we, proc_done, proc_en;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;
   logic       rx_LED, tx_LED, enable_check;

   // Second instance: full address space (16 bytes with ADDR_W=4)
   logic       receive2;
   logic [7:0] rx_data2;
   logic       rx_valid2;
   logic [7:0] tx_data2;
   logic       tx_start2, proc_en2;
   logic [3:0] mem_addr2;
   logic [7:0] mem_wdata2;
   logic       mem_we2;
   logic [7:0] mem_rdata2;
   logic       rx_LED2, tx_LED2, enable_check2;
   logic       zero1;
   logic [3:0] zero4;
   logic [7:0] zero8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_mem_ctrl #(.ADDR_W(4), .IMG_BYTES(4)) dut (
      .clk(clk), .reset(reset), .receive(receive), .send(send), .enablle(enablle),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy), .tx_data(tx_data),
      .tx_start(tx_start), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
      .proc_we(proc_we), .proc_done(proc_done), .proc_en(proc_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .rx_LED(rx_LED), .tx_LED(tx_LED),
      .enable_check(enable_check)
   );

   uart_mem_ctrl #(.ADDR_W(4), .IMG_BYTES(16)) dut16 (
      .clk(clk), .reset(reset), .receive(receive2), .send(zero1), .enablle(zero1),
      .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_busy(zero1), .tx_data(tx_data2),
      .tx_start(tx_start2), .proc_addr(zero4), .proc_wdata(zero8),
      .proc_we(zero1), .proc_done(zero1), .proc_en(proc_en2),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
      .mem_rdata(mem_rdata2), .rx_LED(rx_LED2), .tx_LED(tx_LED2),
      .enable_check(enable_check2)
   );

   // Memory models: synchronous write, read data one cycle after address
   logic [7:0] mem  [16];
   logic [7:0] mem2 [16];
   int         wr_cnt = 0;
   int         wr_cnt2 = 0;
   logic [3:0] last_wr_addr = '0;
   logic [3:0] last_wr_addr2 = '0;
   logic [3:0] wr_log [$];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 1;
         last_wr_addr  <= mem_addr;
         wr_log.push_back(mem_addr);
      end
      mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_we2) begin
         mem2[mem_addr2] <= mem_wdata2;
         wr_cnt2         <= wr_cnt2 + 1;
         last_wr_addr2   <= mem_addr2;
      end
      mem_rdata2 <= mem2[mem_addr2];
   end

   // uart_tx model: busy for 10 cycles after each start
   int         busy_cnt = 0;
   int         busy_viol = 0;
   logic [7:0] tx_log [$];

   assign tx_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      if (tx_start) begin
         tx_log.push_back(tx_data);
         if (tx_busy) busy_viol <= busy_viol + 1;
         busy_cnt <= 10;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_recv();
      receive = 1'b1; tick(); receive = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic pulse_send();
      send = 1'b1; tick(); send = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic rx_byte(input logic [7:0] d);
      rx_data = d; rx_valid = 1'b1; tick();
      rx_valid = 1'b0; tick(); tick();
   endtask

   task automatic wait_tx_idle(input string tag);
      for (int i = 0; i < 2000; i++) begin
         if (!tx_LED) break;
         tick();
      end
      check(tag, tx_LED, 1'b0);
   endtask

   task automatic check_tx(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
      logic [7:0] e [4];
      e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
      check({tag, "_count"}, tx_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < tx_log.size()) check($sformatf("%s_byte%0d", tag, i), tx_log[i], e[i]);
      end
   endtask

   initial begin
      reset = 1'b1; receive = 1'b1; send = 1'b0; enablle = 1'b0;
      rx_data = '0; rx_valid = 1'b0;
      proc_addr = '0; proc_wdata = '0; proc_we = 1'b0; proc_done = 1'b0;
      receive2 = 1'b0; rx_data2 = '0; rx_valid2 = 1'b0;
      zero1 = 1'b0; zero4 = '0; zero8 = '0;
      for (int i = 0; i < 16; i++) begin mem[i] = '0; mem2[i] = '0; end

      // Reset held with receive high: nothing starts, outputs at reset values
      for (int i = 0; i < 5; i++) tick();
      check("rst_rx_led", rx_LED, 1'b0);
      check("rst_outputs", {tx_start, proc_en, tx_LED, enable_check, mem_we}, 5'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_mem_addr", mem_addr, 4'h0);
      receive = 1'b0; tick();
      reset = 1'b0; tick(); tick(); tick();
      check("post_rst_idle", rx_LED, 1'b0);

      // Load 4 bytes
      pulse_recv();
      check("rx_enter", rx_LED, 1'b1);
      rx_byte(8'hA1); rx_byte(8'hB2); rx_byte(8'hC3); rx_byte(8'hD4);
      check("rx_exit", rx_LED, 1'b0);
      check("rx_wr_cnt", wr_cnt, 4);
      check("rx_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'hA1B2C3D4);
      check("rx_addrs", {wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, 16'h0123);
      rx_byte(8'hEE);
      check("rx_idle_ignored", wr_cnt, 4);

      // Dump 4 bytes
      pulse_send();
      check("tx_enter", tx_LED, 1'b1);
      wait_tx_idle("tx1_done");
      check_tx("tx1", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      check("tx1_busy_viol", busy_viol, 0);

      // Simultaneous receive and send: receive wins, send dropped
      tx_log.delete();
      receive = 1'b1; send = 1'b1; tick(); receive = 1'b0; send = 1'b0;
      tick(); tick(); tick();
      check("prio_rx", {rx_LED, tx_LED}, 2'b10);
      rx_byte(8'hA1); rx_byte(8'hB2); rx_byte(8'hC3); rx_byte(8'hD4);
      for (int i = 0; i < 20; i++) tick();
      check("prio_no_tx", tx_log.size(), 0);
      check("prio_idle", {rx_LED, tx_LED}, 2'b00);

      // Run the core
      enablle = 1'b1; tick(); enablle = 1'b0; tick(); tick(); tick();
      check("run_en", {proc_en, enable_check}, 2'b11);
      rx_byte(8'h99);
      check("run_rx_ignored", wr_cnt, 8);
      proc_addr = 4'd2; proc_wdata = 8'h55; proc_we = 1'b1; #1;
      check("run_mux", {mem_addr, mem_wdata, mem_we}, {4'd2, 8'h55, 1'b1});
      tick(); proc_we = 1'b0; proc_addr = '0; proc_wdata = '0;
      check("run_write", mem[2], 8'h55);
      proc_done = 1'b1; #1;
      check("done_same_cycle", proc_en, 1'b1);
      tick();
      check("done_next_cycle", {proc_en, enable_check}, 2'b00);
      proc_done = 1'b0; tick();

      // Dump after core write
      tx_log.delete();
      pulse_send();
      wait_tx_idle("tx2_done");
      check_tx("tx2", 8'hA1, 8'hB2, 8'h55, 8'hD4);
      check("tx2_busy_viol", busy_viol, 0);

      // Reset mid-receive, then restart at address 0
      pulse_recv();
      rx_byte(8'hE1); rx_byte(8'hE2);
      check("abort_partial", last_wr_addr, 4'd1);
      reset = 1'b1; tick(); tick();
      check("abort_outputs", {rx_LED, tx_LED, enable_check, proc_en, tx_start, mem_we}, 6'b0);
      check("abort_tx_data", tx_data, 8'h00);
      reset = 1'b0; tick();
      check("abort_mem_kept", {mem[0], mem[1]}, 16'hE1E2);
      pulse_recv();
      rx_byte(8'hF0);
      check("restart_addr0", last_wr_addr, 4'd0);
      check("restart_data", mem[0], 8'hF0);
      rx_byte(8'hF1); rx_byte(8'hF2); rx_byte(8'hF3);
      check("restart_done", rx_LED, 1'b0);

      // Full address space: 16 writes, 17th ignored
      receive2 = 1'b1; tick(); receive2 = 1'b0; tick(); tick(); tick();
      check("full_enter", rx_LED2, 1'b1);
      for (int i = 0; i < 17; i++) begin
         rx_data2 = 8'(8'h10 + i); rx_valid2 = 1'b1; tick();
         rx_valid2 = 1'b0; tick();
      end
      check("full_wr_cnt", wr_cnt2, 16);
      check("full_last_addr", last_wr_addr2, 4'd15);
      check("full_no_wrap", mem2[0], 8'h10);
      check("full_last_data", mem2[15], 8'h1F);
      check("full_exit", rx_LED2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
